// File: rtl/ball_pkg.sv
// Shared definitions for the ball project score logic: BCD digit limits,
// request width and the score counter state encoding.
package ball_pkg;

    localparam int DIGIT_W = 4;
    localparam int AMT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Out-of-range BCD digits are treated as the largest legal digit.
    function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_inc.sv
// Combinational single-digit BCD incrementer: adds cin to one digit and
// produces the carry into the next digit.
module bcd_digit_inc
    import ball_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    input  logic               cin,
    output logic [DIGIT_W-1:0] dout,
    output logic               cout
);

    always_comb begin
        dout = din;
        cout = 1'b0;
        if (cin) begin
            if (din >= BCD_MAX) begin
                dout = '0;
                cout = 1'b1;
            end else begin
                dout = din + 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_score_counter.sv
// Multi-digit BCD score counter: accepts point amounts over valid/ready and
// applies them one BCD increment per enabled clock, flagging overflow on CO.
module bcd_score_counter
    import ball_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                       CP,
    input  logic                       CR,
    input  logic                       Ld,
    input  logic [DIGIT_W*DIGITS-1:0]  D,
    input  logic                       EN,
    input  logic                       add_valid,
    input  logic [AMT_W-1:0]           add_amt,
    output logic                       add_ready,
    output logic                       busy,
    output logic [DIGIT_W*DIGITS-1:0]  Q,
    output logic                       CO
);

    localparam int QW = DIGIT_W * DIGITS;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [QW-1:0]    q_q, q_d;
    logic             co_q, co_d;

    logic [DIGITS:0]  carry;
    logic [QW-1:0]    inc_val;
    logic [QW-1:0]    load_val;
    logic             overflow;

    // Ripple carry through the digit chain; carry out of the top digit means
    // every digit was 9.
    assign carry[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_inc u_inc (
            .din  (q_q[DIGIT_W*g +: DIGIT_W]),
            .cin  (carry[g]),
            .dout (inc_val[DIGIT_W*g +: DIGIT_W]),
            .cout (carry[g+1])
        );
    end

    assign overflow = carry[DIGITS];

    always_comb begin
        load_val = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_val[DIGIT_W*i +: DIGIT_W] = bcd_clamp(D[DIGIT_W*i +: DIGIT_W]);
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        q_d     = q_q;
        co_d    = 1'b0;
        if (!Ld) begin
            q_d     = load_val;
            rem_d   = '0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (add_valid && (add_amt != '0)) begin
                        rem_d   = add_amt;
                        state_d = COUNT;
                    end
                end
                COUNT: begin
                    if (EN) begin
                        co_d  = overflow;
                        q_d   = (overflow && SATURATE) ? q_q : inc_val;
                        rem_d = rem_q - AMT_W'(1);
                        if (rem_q == AMT_W'(1)) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            state_q <= IDLE;
            rem_q   <= '0;
            q_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            co_q    <= co_d;
        end
    end

    assign add_ready = (state_q == IDLE);
    assign busy      = (state_q == COUNT);
    assign Q         = q_q;
    assign CO        = co_q;

endmodule
